mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-low. Ports are clk_i and rstn_i.
REQ-002 Parameter: MAX_WAIT, default 4, the number of consecutive lost fetch arbitrations before fetch is forced to win.
REQ-003 clk_i  in  1  clock; all state updates on the rising edge.
REQ-004 rstn_i  in  1  asynchronous active-low reset.
REQ-005 if_req_i  in  1  fetch read request; held until if_gnt_o.
REQ-006 if_addr_i  in  32 (bus32_t)  fetch word address.
REQ-007 if_kill_i  in  1  fetch flush (branch taken); discards any fetch request or fetch response.
REQ-008 if_gnt_o  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid_o / if_rdata_o  out  1 / 32  fetch response pulse and data.
REQ-010 dm_req_i, dm_we_i  in  1, 1  data request; write enable; held until dm_gnt_o.
REQ-011 dm_addr_i, dm_wdata_i  in  32, 32  data address and write data.
REQ-012 dm_gnt_o, dm_rvalid_o, dm_rdata_o  out  1, 1, 32  data accept, response pulse, read data.
REQ-013 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o  out  1, 1, 32, 32  shared memory request; all fields registered.
REQ-014 mem_gnt_i, mem_rvalid_i, mem_rdata_i  in  1, 1, 32  memory accept; memory response, one per request including writes; read data.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ (mem_req_o=1, waiting for mem_gnt_i) and WAIT (waiting for mem_rvalid_i); one transaction is outstanding at most.
REQ-016 In IDLE, a grant SHALL be issued combinationally: the winner's gnt is 1, the winner's addr/we/wdata and owner are latched, and the next state is REQ.
REQ-017 Arbitration SHALL be data-priority: dm wins unless starve_cnt==MAX_WAIT and if_req_i=1, in which case fetch wins.
REQ-018 starve_cnt SHALL increment on every IDLE cycle where both requests are present and dm wins, and SHALL clear when fetch is granted; it SHALL saturate at MAX_WAIT.
REQ-019 If if_kill_i=1 in IDLE, fetch SHALL NOT be granted that cycle; dm MAY be granted.
REQ-020 In REQ, mem_req_o and all mem_* fields SHALL stay stable until the mem_gnt_i cycle, after which the next state is WAIT; the request is never withdrawn.
REQ-021 In WAIT, when mem_rvalid_i=1, the owner's rvalid_o SHALL be 1 in the same cycle with rdata_o=mem_rdata_i, and the next state is IDLE.
REQ-022 A non-owner rvalid_o SHALL be 0, and any rdata_o without its rvalid_o SHALL be 0; for writes, dm_rdata_o is don't-care.
REQ-023 If if_kill_i=1 in REQ or WAIT while the owner is fetch, a drop flag SHALL be set; the transaction completes, but if_rvalid_o is suppressed for it.
REQ-024 The drop flag SHALL clear on return to IDLE.
REQ-025 mem_rvalid_i or mem_gnt_i outside their states SHALL be ignored.
REQ-026 Minimum turnaround: grant at N, mem_req_o at N+1, response at N+2 at the earliest, next grant at N+3.

Reset
REQ-027 While rstn_i=0, the FSM SHALL be IDLE; starve_cnt, owner and drop SHALL be 0; mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o SHALL be 0.
REQ-028 Assertion of reset mid-transaction SHALL abandon the transaction, and no rvalid_o SHALL be produced for it after release.

Structure
REQ-029 The types arb_state_t {IDLE, REQ, WAIT} and arb_owner_t {OWN_IF, OWN_DM}, and the default MEM_ARB_MAX_WAIT=4, SHALL live in tartaruga_pkg.
REQ-030 The block SHALL be a single module with no sub-modules.

Verification
REQ-031 Fetch-only read: if_req=1, addr=0x100, mem_gnt at the next cycle, rvalid 2 cycles later with data 0x00500093 -> if_gnt at cycle 0, mem_addr_o=0x100 at cycle 1, if_rvalid with rdata 0x00500093, dm_rvalid=0.
REQ-032 Simultaneous requests: if_req=1 and dm_req=1 (addr 0x2000, write, 0xDEADBEEF) -> dm is granted first with mem_we_o=1 and mem_wdata_o=0xDEADBEEF; fetch is granted next IDLE.
REQ-033 Starvation: dm_req held high continuously with if_req=1, MAX_WAIT=4 -> four dm grants, then the fifth grant goes to fetch and starve_cnt returns to 0.
REQ-034 Kill in WAIT: fetch outstanding, if_kill=1 one cycle before mem_rvalid -> if_rvalid_o stays 0, the FSM returns to IDLE, and a subsequent dm request completes normally.
REQ-035 Memory backpressure: mem_gnt_i held low for 5 cycles -> mem_req_o and mem_addr_o stay stable for all 5 cycles; no new grants are issued.
REQ-036 Reset mid-WAIT: rstn_i pulled low, then mem_rvalid_i=1 after release -> no rvalid_o, and all outputs read 0 during reset.

Source files
------------

// File: rtl/tartaruga_pkg.sv
// Shared types and defaults for the tartaruga memory subsystem.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } arb_owner_t;

  localparam int unsigned MEM_ARB_MAX_WAIT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto a single shared memory port.
// Data requests have priority; fetch is forced through after MAX_WAIT
// consecutive lost arbitrations. One transaction is outstanding at most.
module mem_arbiter
  import tartaruga_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MEM_ARB_MAX_WAIT
) (
  input  logic   clk_i,
  input  logic   rstn_i,
  input  logic   if_req_i,
  input  bus32_t if_addr_i,
  input  logic   if_kill_i,
  output logic   if_gnt_o,
  output logic   if_rvalid_o,
  output bus32_t if_rdata_o,
  input  logic   dm_req_i,
  input  logic   dm_we_i,
  input  bus32_t dm_addr_i,
  input  bus32_t dm_wdata_i,
  output logic   dm_gnt_o,
  output logic   dm_rvalid_o,
  output bus32_t dm_rdata_o,
  output logic   mem_req_o,
  output logic   mem_we_o,
  output bus32_t mem_addr_o,
  output bus32_t mem_wdata_o,
  input  logic   mem_gnt_i,
  input  logic   mem_rvalid_i,
  input  bus32_t mem_rdata_i
);

  localparam int unsigned CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  arb_state_t       state;
  arb_state_t       state_nxt;
  arb_owner_t       owner;
  logic             drop;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             if_win;
  logic             dm_win;

  // Arbitration: data wins unless fetch has been starved; a killed fetch never wins.
  // Grants are also held low while reset is asserted so every output reads 0.
  always_comb begin
    starved = (starve_cnt == CNT_MAX);
    if_win  = rstn_i && (state == IDLE) && if_req_i && !if_kill_i &&
              (!dm_req_i || starved);
    dm_win  = rstn_i && (state == IDLE) && dm_req_i && !if_win;
  end

  // Next-state and combinational handshake outputs.
  always_comb begin
    state_nxt   = state;
    if_gnt_o    = if_win;
    dm_gnt_o    = dm_win;
    if_rvalid_o = 1'b0;
    dm_rvalid_o = 1'b0;
    case (state)
      IDLE: begin
        if (if_win || dm_win) state_nxt = REQ;
      end
      REQ: begin
        if (mem_gnt_i) state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          state_nxt = IDLE;
          if (owner == OWN_IF) if_rvalid_o = !drop && !if_kill_i;
          else                 dm_rvalid_o = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if_rdata_o = if_rvalid_o ? mem_rdata_i : '0;
    dm_rdata_o = dm_rvalid_o ? mem_rdata_i : '0;
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Control state: owner, fetch-drop flag, starvation counter, request strobe.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      owner      <= OWN_IF;
      drop       <= 1'b0;
      starve_cnt <= '0;
      mem_req_o  <= 1'b0;
    end else begin
      if (if_win || dm_win) begin
        owner     <= if_win ? OWN_IF : OWN_DM;
        mem_req_o <= 1'b1;
      end
      if ((state == REQ) && mem_gnt_i) mem_req_o <= 1'b0;
      if ((state != IDLE) && (owner == OWN_IF) && if_kill_i) drop <= 1'b1;
      if ((state == WAIT) && mem_rvalid_i) drop <= 1'b0;
      if (if_win) starve_cnt <= '0;
      else if (dm_win && if_req_i && !starved) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Request fields are captured at grant and held until the next grant.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (if_win) begin
      mem_we_o    <= 1'b0;
      mem_addr_o  <= if_addr_i;
      mem_wdata_o <= '0;
    end else if (dm_win) begin
      mem_we_o    <= dm_we_i;
      mem_addr_o  <= dm_addr_i;
      mem_wdata_o <= dm_wdata_i;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants, memory
// requests and responses; a negedge monitor pops and compares them.
module tb_mem_arbiter;
  import tartaruga_pkg::*;

  logic   clk_i = 1'b0;
  logic   rstn_i;
  logic   if_req_i, if_kill_i, if_gnt_o, if_rvalid_o;
  bus32_t if_addr_i, if_rdata_o;
  logic   dm_req_i, dm_we_i, dm_gnt_o, dm_rvalid_o;
  bus32_t dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic   mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  bus32_t mem_addr_o, mem_wdata_o, mem_rdata_i;

  mem_arbiter #(.MAX_WAIT(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_kill_i(if_kill_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
    .dm_rdata_o(dm_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_t;
  typedef struct { bit is_dm; bit chk; logic [31:0] data; } rsp_t;

  bit          exp_gnt_q[$];   // 1 = data port, 0 = fetch port
  mem_t        exp_mem_q[$];
  rsp_t        exp_rsp_q[$];
  logic [31:0] mem_data_q[$];

  int checks = 0;
  int errors = 0;

  // memory model controls
  bit mem_auto  = 1'b1;
  int gnt_delay = 0;
  int rsp_delay = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- monitor ----------------
  logic        p_req = 1'b0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;

  always @(negedge clk_i) begin
    bit   eg;
    mem_t em;
    rsp_t er;
    if (if_gnt_o || dm_gnt_o) begin
      check("gnt_exclusive", {31'd0, if_gnt_o & dm_gnt_o}, 32'd0);
      check("gnt_while_busy", {31'd0, mem_req_o}, 32'd0);
      if (exp_gnt_q.size() == 0) fail_now("gnt_unexpected");
      else begin
        eg = exp_gnt_q.pop_front();
        check("gnt_owner_is_dm", {31'd0, dm_gnt_o}, {31'd0, eg});
      end
    end
    if (mem_req_o && !p_req) begin
      if (exp_mem_q.size() == 0) fail_now("mem_req_unexpected");
      else begin
        em = exp_mem_q.pop_front();
        check("mem_we", {31'd0, mem_we_o}, {31'd0, em.we});
        check("mem_addr", mem_addr_o, em.addr);
        check("mem_wdata", mem_wdata_o, em.wdata);
      end
    end else if (mem_req_o && p_req) begin
      check("mem_stable_we", {31'd0, mem_we_o}, {31'd0, p_we});
      check("mem_stable_addr", mem_addr_o, p_addr);
      check("mem_stable_wdata", mem_wdata_o, p_wdata);
    end
    if (if_rvalid_o || dm_rvalid_o) begin
      check("rvalid_exclusive", {31'd0, if_rvalid_o & dm_rvalid_o}, 32'd0);
      if (exp_rsp_q.size() == 0) fail_now("rvalid_unexpected");
      else begin
        er = exp_rsp_q.pop_front();
        check("rsp_is_dm", {31'd0, dm_rvalid_o}, {31'd0, er.is_dm});
        if (er.chk) check("rsp_data", er.is_dm ? dm_rdata_o : if_rdata_o, er.data);
      end
    end
    if (!if_rvalid_o) check("if_rdata_idle_zero", if_rdata_o, 32'd0);
    if (!dm_rvalid_o) check("dm_rdata_idle_zero", dm_rdata_o, 32'd0);
    p_req   <= mem_req_o;
    p_we    <= mem_we_o;
    p_addr  <= mem_addr_o;
    p_wdata <= mem_wdata_o;
  end

  // ---------------- memory responder ----------------
  initial begin
    int mstate, cnt;
    mstate = 0;
    cnt    = 0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (!mem_auto || !rstn_i) begin
        mstate = 0;
      end else begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        case (mstate)
          0: if (mem_req_o) begin
            if (gnt_delay == 0) begin mem_gnt_i = 1'b1; mstate = 2; cnt = rsp_delay; end
            else begin cnt = gnt_delay; mstate = 1; end
          end
          1: begin
            cnt--;
            if (cnt == 0) begin mem_gnt_i = 1'b1; mstate = 2; cnt = rsp_delay; end
          end
          default: begin
            if (cnt == 0) begin
              mem_rvalid_i = 1'b1;
              mem_rdata_i  = (mem_data_q.size() != 0) ? mem_data_q.pop_front() : 32'd0;
              mstate = 0;
            end else cnt--;
          end
        endcase
      end
    end
  end

  // ---------------- requester tasks ----------------
  task automatic req_if(input logic [31:0] a, input bit chk_starve);
    bit ok = 0;
    if_req_i = 1'b1; if_addr_i = a;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (if_gnt_o) begin ok = 1; break; end
    end
    if (!ok) fail_now("if_gnt_timeout");
    else if (chk_starve) check("starve_cnt_at_forced_fetch", 32'(dut.starve_cnt), 32'd4);
    @(posedge clk_i); #1;
    if_req_i = 1'b0; if_addr_i = '0;
  endtask

  task automatic req_dm(input logic we, input logic [31:0] a, input logic [31:0] d);
    bit ok = 0;
    dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = a; dm_wdata_i = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (dm_gnt_o) begin ok = 1; break; end
    end
    if (!ok) fail_now("dm_gnt_timeout");
    @(posedge clk_i); #1;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (exp_gnt_q.size() == 0 && exp_mem_q.size() == 0 &&
          exp_rsp_q.size() == 0 && !mem_req_o) begin ok = 1; break; end
    end
    if (!ok) fail_now("drain_timeout");
    @(posedge clk_i); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},   {31'd0, mem_req_o},   32'd0);
    check({tag, "_mem_we"},    {31'd0, mem_we_o},    32'd0);
    check({tag, "_mem_addr"},  mem_addr_o,           32'd0);
    check({tag, "_mem_wdata"}, mem_wdata_o,          32'd0);
    check({tag, "_if_gnt"},    {31'd0, if_gnt_o},    32'd0);
    check({tag, "_dm_gnt"},    {31'd0, dm_gnt_o},    32'd0);
    check({tag, "_if_rvalid"}, {31'd0, if_rvalid_o}, 32'd0);
    check({tag, "_dm_rvalid"}, {31'd0, dm_rvalid_o}, 32'd0);
    check({tag, "_if_rdata"},  if_rdata_o,           32'd0);
    check({tag, "_dm_rdata"},  dm_rdata_o,           32'd0);
  endtask

  function automatic mem_t mk_mem(input logic we, input logic [31:0] a, input logic [31:0] d);
    mem_t m;
    m.we = we; m.addr = a; m.wdata = d;
    return m;
  endfunction

  function automatic rsp_t mk_rsp(input bit is_dm, input bit chk, input logic [31:0] d);
    rsp_t r;
    r.is_dm = is_dm; r.chk = chk; r.data = d;
    return r;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rstn_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h40; if_kill_i = 1'b0;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h44; dm_wdata_i = 32'h55;

    // reset: requests present but everything must read 0
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    if_req_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    @(posedge clk_i); #1;
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // fetch-only read
    gnt_delay = 0; rsp_delay = 1;
    exp_gnt_q.push_back(1'b0);
    exp_mem_q.push_back(mk_mem(1'b0, 32'h100, 32'h0));
    mem_data_q.push_back(32'h00500093);
    exp_rsp_q.push_back(mk_rsp(1'b0, 1'b1, 32'h00500093));
    req_if(32'h100, 1'b0);
    check("t1_mem_req_cycle1", {31'd0, mem_req_o}, 32'd1);
    check("t1_mem_addr_cycle1", mem_addr_o, 32'h100);
    drain();

    // simultaneous: data write first, fetch next
    rsp_delay = 0;
    exp_gnt_q.push_back(1'b1);
    exp_gnt_q.push_back(1'b0);
    exp_mem_q.push_back(mk_mem(1'b1, 32'h2000, 32'hDEADBEEF));
    exp_mem_q.push_back(mk_mem(1'b0, 32'h300, 32'h0));
    mem_data_q.push_back(32'h11111111);
    mem_data_q.push_back(32'hCAFE0001);
    exp_rsp_q.push_back(mk_rsp(1'b1, 1'b0, 32'h0));
    exp_rsp_q.push_back(mk_rsp(1'b0, 1'b1, 32'hCAFE0001));
    fork
      req_if(32'h300, 1'b0);
      req_dm(1'b1, 32'h2000, 32'hDEADBEEF);
    join
    drain();

    // starvation: four data wins, fifth goes to fetch, then data again
    for (int k = 0; k < 4; k++) begin
      exp_gnt_q.push_back(1'b1);
      exp_mem_q.push_back(mk_mem(1'b0, 32'h4000 + 32'(4 * k), 32'h0));
      mem_data_q.push_back(32'hD0 + 32'(k));
      exp_rsp_q.push_back(mk_rsp(1'b1, 1'b1, 32'hD0 + 32'(k)));
    end
    exp_gnt_q.push_back(1'b0);
    exp_mem_q.push_back(mk_mem(1'b0, 32'h3000, 32'h0));
    mem_data_q.push_back(32'hF00D0000);
    exp_rsp_q.push_back(mk_rsp(1'b0, 1'b1, 32'hF00D0000));
    exp_gnt_q.push_back(1'b1);
    exp_mem_q.push_back(mk_mem(1'b0, 32'h4010, 32'h0));
    mem_data_q.push_back(32'hD4);
    exp_rsp_q.push_back(mk_rsp(1'b1, 1'b1, 32'hD4));
    fork
      begin
        for (int k = 0; k < 5; k++) req_dm(1'b0, 32'h4000 + 32'(4 * k), 32'h0);
      end
      req_if(32'h3000, 1'b1);
    join
    drain();
    check("starve_cnt_after", 32'(dut.starve_cnt), 32'd0);

    // kill in WAIT: fetch response suppressed, later traffic normal
    mem_auto = 1'b0;
    exp_gnt_q.push_back(1'b0);
    exp_mem_q.push_back(mk_mem(1'b0, 32'h500, 32'h0));
    req_if(32'h500, 1'b0);
    mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    @(posedge clk_i); #1;
    if_kill_i = 1'b1;
    @(posedge clk_i); #1;
    if_kill_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
    @(negedge clk_i);
    check("t4_if_rvalid_dropped", {31'd0, if_rvalid_o}, 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("t4_stray_rvalid_if", {31'd0, if_rvalid_o}, 32'd0);
    check("t4_stray_rvalid_dm", {31'd0, dm_rvalid_o}, 32'd0);
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_auto = 1'b1;
    exp_gnt_q.push_back(1'b1);
    exp_mem_q.push_back(mk_mem(1'b0, 32'h5004, 32'h0));
    mem_data_q.push_back(32'h12345678);
    exp_rsp_q.push_back(mk_rsp(1'b1, 1'b1, 32'h12345678));
    req_dm(1'b0, 32'h5004, 32'h0);
    drain();
    exp_gnt_q.push_back(1'b0);
    exp_mem_q.push_back(mk_mem(1'b0, 32'h504, 32'h0));
    mem_data_q.push_back(32'h0000ABCD);
    exp_rsp_q.push_back(mk_rsp(1'b0, 1'b1, 32'h0000ABCD));
    req_if(32'h504, 1'b0);
    drain();

    // backpressure: grant held off for 5 cycles
    gnt_delay = 5;
    exp_gnt_q.push_back(1'b0);
    exp_gnt_q.push_back(1'b1);
    exp_mem_q.push_back(mk_mem(1'b0, 32'h600, 32'h0));
    exp_mem_q.push_back(mk_mem(1'b0, 32'h700, 32'h0));
    mem_data_q.push_back(32'h66);
    mem_data_q.push_back(32'h77);
    exp_rsp_q.push_back(mk_rsp(1'b0, 1'b1, 32'h66));
    exp_rsp_q.push_back(mk_rsp(1'b1, 1'b1, 32'h77));
    req_if(32'h600, 1'b0);
    fork
      req_dm(1'b0, 32'h700, 32'h0);
    join_none
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (mem_req_o) n++;
      else break;
    end
    check("t5_mem_req_cycles", 32'(n), 32'd6);
    drain();
    wait fork;
    gnt_delay = 0;

    // reset mid-WAIT: transaction abandoned, no late response
    mem_auto = 1'b0;
    exp_gnt_q.push_back(1'b0);
    exp_mem_q.push_back(mk_mem(1'b0, 32'h800, 32'h0));
    req_if(32'h800, 1'b0);
    mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    rstn_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
    dm_req_i = 1'b1; dm_addr_i = 32'h900;
    #1;
    check_all_zero("midrst");
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    dm_req_i = 1'b0; dm_addr_i = '0;
    rstn_i = 1'b1;
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
    @(negedge clk_i);
    check("t6_if_rvalid_after_rst", {31'd0, if_rvalid_o}, 32'd0);
    check("t6_dm_rvalid_after_rst", {31'd0, dm_rvalid_o}, 32'd0);
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_auto = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    check("end_gnt_queue_empty", 32'(exp_gnt_q.size()), 32'd0);
    check("end_mem_queue_empty", 32'(exp_mem_q.size()), 32'd0);
    check("end_rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
